cpu_bus_ctrl: RTL and testbench

- Bus sequencer between the 6502 core and the memories/peripherals of the 1581 drive model.
- Divides the system clock into 6502 bus cycles and latches the CPU address, R/W and write data.
- Decodes the 1581 memory map and strobes ROM_23256, RAM, CIA or WD177x, then captures read data after the target's latency.
- Presents the captured data to the CPU and emits the CPU clock-enable.

---
 rtl/cpu_bus_pkg.sv | 38 +++
 rtl/cpu_addr_decode.sv | 35 +++
 rtl/cpu_bus_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types for the 1581 drive 6502 bus sequencer.
// Region enum, memory-map constants and FSM state encoding.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CIA,
        REG_FDC,
        REG_ROM,
        REG_NONE
    } region_e;

    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] RAM_MASK = 16'hE000;
    localparam logic [15:0] CIA_BASE = 16'h4000;
    localparam logic [15:0] CIA_MASK = 16'hFC00;
    localparam logic [15:0] FDC_BASE = 16'h6000;
    localparam logic [15:0] FDC_MASK = 16'hFC00;
    localparam logic [15:0] ROM_BASE = 16'h8000;
    localparam logic [15:0] ROM_MASK = 16'h8000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_HOLD    = 3'd6;

    function automatic logic in_map(
        input logic [15:0] a,
        input logic [15:0] base,
        input logic [15:0] mask
    );
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/cpu_addr_decode.sv
// cpu_addr_decode: 1581 memory map, address -> region and local offset.
// Purely combinational so the debugger can share it.
module cpu_addr_decode
    import cpu_bus_pkg::*;
(
    input  logic [15:0] addr,
    output region_e     region,
    output logic [14:0] offset
);

    always_comb begin
        region = REG_NONE;
        offset = '0;
        unique case (1'b1)
            in_map(addr, RAM_BASE, RAM_MASK): begin
                region = REG_RAM;
                offset = addr[14:0] & ~RAM_MASK[14:0];
            end
            in_map(addr, CIA_BASE, CIA_MASK): begin
                region = REG_CIA;
                offset = addr[14:0] & ~CIA_MASK[14:0];
            end
            in_map(addr, FDC_BASE, FDC_MASK): begin
                region = REG_FDC;
                offset = addr[14:0] & ~FDC_MASK[14:0];
            end
            in_map(addr, ROM_BASE, ROM_MASK): begin
                region = REG_ROM;
                offset = addr[14:0] & ~ROM_MASK[14:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: divides clk into 6502 bus cycles, strobes the addressed
// target and hands captured read data plus a clock-enable to the CPU.
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ce,
    output logic [14:0] rom_addr,
    output logic        rom_oe,
    input  logic [7:0]  rom_data,
    output logic [12:0] ram_addr,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        cia_cs,
    output logic        fdc_cs,
    output logic [3:0]  io_addr,
    output logic        io_rw,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  cia_rdata,
    input  logic [7:0]  fdc_rdata
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_CS_END = PW'(CLK_DIV - 2);

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [PW-1:0] p;
    logic [PW-1:0] p_n;

    region_e       dec_region;
    logic [14:0]   dec_off;
    region_e       region_q;
    logic          rw_q;

    logic          rom_oe_q;
    logic          ram_oe_q;
    logic          ram_we_q;
    logic          cia_cs_q;
    logic          fdc_cs_q;
    logic          ce_q;
    logic [7:0]    din_q;

    logic          go;
    logic          in_cycle;
    logic          cs_end;
    logic          is_mem;
    logic          is_io;
    logic          cap_mem;
    logic          cap_io;

    cpu_addr_decode u_dec (
        .addr   (cpu_addr),
        .region (dec_region),
        .offset (dec_off)
    );

    assign go       = state == ST_SETUP;
    assign in_cycle = (state == ST_ACCESS) ||
                      (state == ST_CAPTURE) ||
                      (state == ST_WAIT);
    assign cs_end   = in_cycle && (p == P_CS_END);
    assign is_mem   = (region_q == REG_ROM) || (region_q == REG_RAM);
    assign is_io    = (region_q == REG_CIA) || (region_q == REG_FDC);
    assign cap_mem  = (state == ST_CAPTURE) && rw_q && is_mem;
    assign cap_io   = cs_end && rw_q && is_io;

    always_comb begin
        state_n = state;
        p_n     = p;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (!hold) begin
                    state_n = ST_SETUP;
                    p_n     = '0;
                end
            end
            ST_SETUP: begin
                state_n = ST_ACCESS;
                p_n     = PW'(1);
            end
            ST_ACCESS: begin
                state_n = ST_CAPTURE;
                p_n     = PW'(2);
            end
            ST_CAPTURE, ST_WAIT: begin
                p_n     = p + 1'b1;
                state_n = (p_n == P_LAST) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                p_n     = '0;
                state_n = hold ? ST_HOLD : ST_SETUP;
            end
            default: begin
                state_n = ST_IDLE;
                p_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            p         <= '0;
            region_q  <= REG_NONE;
            rw_q      <= 1'b1;
            rom_oe_q  <= 1'b0;
            ram_oe_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            cia_cs_q  <= 1'b0;
            fdc_cs_q  <= 1'b0;
            ce_q      <= 1'b0;
            din_q     <= 8'hFF;
            rom_addr  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            io_addr   <= '0;
            io_rw     <= 1'b1;
            io_wdata  <= '0;
        end else begin
            state    <= state_n;
            p        <= p_n;
            ce_q     <= cs_end;
            rom_oe_q <= go && (dec_region == REG_ROM) && cpu_rw;
            ram_oe_q <= go && (dec_region == REG_RAM) && cpu_rw;
            ram_we_q <= go && (dec_region == REG_RAM) && !cpu_rw;

            if (go) begin
                region_q <= dec_region;
                rw_q     <= cpu_rw;
                cia_cs_q <= dec_region == REG_CIA;
                fdc_cs_q <= dec_region == REG_FDC;
            end else if (cs_end) begin
                cia_cs_q <= 1'b0;
                fdc_cs_q <= 1'b0;
            end

            // Only the targeted port's address/data move; ROM writes
            // and unmapped accesses leave every bus output untouched.
            if (go) begin
                case (dec_region)
                    REG_ROM: begin
                        if (cpu_rw)
                            rom_addr <= dec_off;
                    end
                    REG_RAM: begin
                        ram_addr <= dec_off[12:0];
                        if (!cpu_rw)
                            ram_wdata <= cpu_dout;
                    end
                    REG_CIA, REG_FDC: begin
                        io_addr <= dec_off[3:0];
                        io_rw   <= cpu_rw;
                        if (!cpu_rw)
                            io_wdata <= cpu_dout;
                    end
                    default: ;
                endcase
            end

            if (cap_mem)
                din_q <= (region_q == REG_ROM) ? rom_data : ram_rdata;
            else if (cap_io)
                din_q <= (region_q == REG_CIA) ? cia_rdata : fdc_rdata;
        end
    end

    // Gating with rst kills a strobe in the very clk reset appears,
    // so an in-flight RAM or peripheral write never lands.
    assign rom_oe  = rom_oe_q & ~rst;
    assign ram_oe  = ram_oe_q & ~rst;
    assign ram_we  = ram_we_q & ~rst;
    assign cia_cs  = cia_cs_q & ~rst;
    assign fdc_cs  = fdc_cs_q & ~rst;
    assign cpu_ce  = ce_q & ~rst;
    assign cpu_din = din_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: randomized bus cycles against a phase-table model
// of the 1581 bus sequencer, with ROM/RAM/peripheral device models.
module tb_cpu_bus_ctrl;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        cpu_ce;
    logic [14:0] rom_addr;
    logic        rom_oe;
    logic [7:0]  rom_data;
    logic [12:0] ram_addr;
    logic        ram_oe;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        cia_cs;
    logic        fdc_cs;
    logic [3:0]  io_addr;
    logic        io_rw;
    logic [7:0]  io_wdata;
    logic [7:0]  cia_rdata = '0;
    logic [7:0]  fdc_rdata = '0;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int rel_cyc = 0;
    bit chk_first = 0;

    logic [7:0]  e_din;
    logic [14:0] e_rom_addr;
    logic [12:0] e_ram_addr;
    logic [7:0]  e_ram_wd;
    logic [3:0]  e_io_addr;
    logic        e_io_rw;
    logic [7:0]  e_io_wd;
    bit   [7:0]  ram_ref [8192];

    cpu_bus_ctrl #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_ce    (cpu_ce),
        .rom_addr  (rom_addr),
        .rom_oe    (rom_oe),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .cia_cs    (cia_cs),
        .fdc_cs    (fdc_cs),
        .io_addr   (io_addr),
        .io_rw     (io_rw),
        .io_wdata  (io_wdata),
        .cia_rdata (cia_rdata),
        .fdc_rdata (fdc_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_img(input logic [14:0] a);
        if (a == 15'h7FFC)
            return 8'h2B;
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    // Registered ROM: data valid the clk after oe, high-Z otherwise.
    logic [7:0] rom_q;
    logic       rom_v = 1'b0;
    always @(posedge clk) begin
        rom_v <= rom_oe;
        if (rom_oe)
            rom_q <= rom_img(rom_addr);
    end
    assign rom_data = rom_v ? rom_q : 8'hzz;

    bit [7:0] ram_mem [8192];
    always @(posedge clk) begin
        if (ram_we)
            ram_mem[ram_addr] <= ram_wdata;
        if (ram_oe)
            ram_rdata <= ram_mem[ram_addr];
    end

    // 0 RAM, 1 CIA, 2 FDC, 3 ROM, 4 unmapped
    function automatic int region(input logic [15:0] a);
        if (a < 16'h2000) return 0;
        if (a >= 16'h4000 && a < 16'h4400) return 1;
        if (a >= 16'h6000 && a < 16'h6400) return 2;
        if (a >= 16'h8000) return 3;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input logic [5:0] es);
        chk("strobes", 32'({rom_oe, ram_oe, ram_we, cia_cs, fdc_cs, cpu_ce}),
            32'(es));
        chk("cpu_din", 32'(cpu_din), 32'(e_din));
        chk("rom_addr", 32'(rom_addr), 32'(e_rom_addr));
        chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_ram_wd));
        chk("io", 32'({io_addr, io_rw, io_wdata}),
            32'({e_io_addr, e_io_rw, e_io_wd}));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hold = 1'b0;
        e_din      = 8'hFF;
        e_rom_addr = '0;
        e_ram_addr = '0;
        e_ram_wd   = '0;
        e_io_addr  = '0;
        e_io_rw    = 1'b1;
        e_io_wd    = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outs(6'b0);
        end
        rst = 1'b0;
        rel_cyc = cyc;
        chk_first = 1;
    endtask

    // One full bus cycle, entered just before the SETUP clk.
    task automatic bus_cycle(input logic [15:0] a, input logic rw,
                             input logic [7:0] d, input logic [7:0] pdat,
                             input int hold_n, input bit rnd_hold);
        int rg;
        logic [7:0] newd;
        logic [5:0] es;
        rg = region(a);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_dout  = d;
        cia_rdata = pdat;
        fdc_rdata = ~pdat;
        newd = e_din;
        if (rw) begin
            case (rg)
                0: newd = ram_ref[a[12:0]];
                1: newd = cia_rdata;
                2: newd = fdc_rdata;
                3: newd = rom_img(a[14:0]);
                default: ;
            endcase
        end
        for (int p = 0; p < D; p++) begin
            @(posedge clk);
            #1;
            if (p == 1) begin
                case (rg)
                    0: begin
                        e_ram_addr = a[12:0];
                        if (!rw) e_ram_wd = d;
                    end
                    1, 2: begin
                        e_io_addr = a[3:0];
                        e_io_rw   = rw;
                        if (!rw) e_io_wd = d;
                    end
                    3: if (rw) e_rom_addr = a[14:0];
                    default: ;
                endcase
            end
            if (rw && (rg == 0 || rg == 3) && p == 3)
                e_din = newd;
            if (rw && (rg == 1 || rg == 2) && p == D - 1)
                e_din = newd;
            es = '0;
            es[5] = (p == 1) && rg == 3 && rw;
            es[4] = (p == 1) && rg == 0 && rw;
            es[3] = (p == 1) && rg == 0 && !rw;
            es[2] = (p >= 1) && (p <= D - 2) && rg == 1;
            es[1] = (p >= 1) && (p <= D - 2) && rg == 2;
            es[0] = (p == D - 1);
            check_outs(es);
            if (chk_first && cpu_ce) begin
                chk("first_ce_clks", 32'(cyc - rel_cyc + 1), 32'd17);
                chk_first = 0;
            end
            if (p == D - 1)
                hold = hold_n > 0;
            else if (p <= D - 3 && rnd_hold)
                hold = 1'($urandom_range(0, 1));
            else
                hold = 1'b0;
        end
        if (!rw && rg == 0)
            ram_ref[a[12:0]] = d;
        for (int i = 0; i < hold_n; i++) begin
            @(posedge clk);
            #1;
            check_outs(6'b0);
        end
        hold = 1'b0;
    endtask

    task automatic abort_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_rw   = 1'b0;
        cpu_dout = d;
        @(posedge clk);
        #1;
        check_outs(6'b0);
        @(posedge clk);
        #1;
        e_ram_addr = a[12:0];
        e_ram_wd   = d;
        check_outs(6'b001000);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(ram_we), 32'd0);
        do_reset();
        chk("abort_mem", 32'(ram_mem[a[12:0]]), 32'(ram_ref[a[12:0]]));
    endtask

    initial begin
        logic [15:0] ra;
        int k;
        int hn;

        do_reset();
        bus_cycle(16'hFFFC, 1'b1, 8'h00, 8'h00, 0, 0);
        bus_cycle(16'h0123, 1'b0, 8'hA5, 8'h00, 0, 0);
        bus_cycle(16'h0123, 1'b1, 8'h00, 8'h00, 0, 0);
        bus_cycle(16'h400D, 1'b1, 8'h00, 8'h81, 0, 0);
        bus_cycle(16'h6001, 1'b0, 8'h3C, 8'h00, 0, 0);
        bus_cycle(16'hFFFC, 1'b1, 8'h00, 8'h00, 0, 0);
        bus_cycle(16'h2000, 1'b1, 8'h00, 8'h00, 0, 0);
        bus_cycle(16'h9000, 1'b0, 8'h77, 8'h00, 0, 0);
        bus_cycle(16'h6002, 1'b1, 8'h00, 8'h18, 5, 0);
        bus_cycle(16'h8001, 1'b1, 8'h00, 8'h00, 0, 0);

        abort_write(16'h0123, 8'h5A);
        bus_cycle(16'h0123, 1'b1, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < 48; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: ra = 16'($urandom_range(0, 16'h1FFF));
                1: ra = 16'h4000 + 16'($urandom_range(0, 16'h03FF));
                2: ra = 16'h6000 + 16'($urandom_range(0, 16'h03FF));
                3: ra = 16'h8000 + 16'($urandom_range(0, 16'h7FFF));
                4: begin
                    case ($urandom_range(0, 2))
                        0: ra = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
                        1: ra = 16'h4400 + 16'($urandom_range(0, 16'h1BFF));
                        default:
                           ra = 16'h6400 + 16'($urandom_range(0, 16'h1BFF));
                    endcase
                end
                default: ra = 16'($urandom_range(0, 15));
            endcase
            hn = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 4) : 0;
            bus_cycle(ra, 1'($urandom_range(0, 1)), 8'($urandom),
                      8'($urandom), hn, 1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
